i2c_slave_regs: RTL and testbench

I2C target (slave) that sits on the same `io_i2c_sda`/`io_i2c_scl` bus as our I2C master and consumes the transactions it produces. The block oversamples both bus lines on the system clock, detects START/STOP, matches a 7-bit address, and receives a register-pointer byte. Data bytes are then written into a local register file, or read back from it, with pointer auto-increment. Each completed write is also exposed as a one-cycle strobe to downstream logic.

---
 rtl/i2c_slave_regs_if.sv | 13 +
 rtl/i2c_slave_regs.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regs_if.sv
// Register-write side of i2c_slave_regs: write strobe with its index/data, and the bus-busy flag.
// The slave modport is the target's view; the master modport is the downstream consumer's view.
interface i2c_slave_regs_if #(
  parameter int PTR_W = 4
);
  logic             or_wr_stb;
  logic [PTR_W-1:0] or_wr_addr;
  logic [7:0]       or_wr_data;
  logic             or_busy;

  modport slave  (output or_wr_stb, or_wr_addr, or_wr_data, or_busy);
  modport master (input  or_wr_stb, or_wr_addr, or_wr_data, or_busy);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-bit register file, a pointer byte, and pointer auto-increment.
// Define I2C_SLAVE_READ_EN to build read support (RDATA/RACK); otherwise reads are NACKed.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         PTR_W      = 4
) (
  input  logic            iw_clk,
  input  logic            iw_reset_n,
  inout  wire             io_i2c_sda,
  inout  wire             io_i2c_scl,
  i2c_slave_regs_if.slave wr_if
);
  localparam int               NREG    = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
`ifdef I2C_SLAVE_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR, S_WDATA, S_ACK_WDATA
`ifdef I2C_SLAVE_READ_EN
    , S_RDATA, S_RACK
`endif
  } state_e;

  // [0],[1] synchronizer stages, [2] history
  logic [2:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             sda_low_q, sda_low_d;
  logic             busy_q, busy_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       regs_q [NREG];
  logic [7:0]       regs_d [NREG];
  logic [7:0]       rx_byte;
  logic             scl_rise, scl_fall, scl_high, start_det, stop_det, sda_bit, addr_hit;

  assign sda_bit   = sda_sync_q[1];
  assign scl_rise  = ~scl_sync_q[2] &  scl_sync_q[1];
  assign scl_fall  =  scl_sync_q[2] & ~scl_sync_q[1];
  assign scl_high  =  scl_sync_q[2] &  scl_sync_q[1];
  assign start_det = scl_high &  sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  = scl_high & ~sda_sync_q[2] &  sda_sync_q[1];
  assign addr_hit  = (rx_byte[7:1] == SLAVE_ADDR) && (!rx_byte[0] || READ_EN);

  assign io_i2c_sda       = sda_low_q ? 1'b0 : 1'bz;
  assign wr_if.or_wr_stb  = wr_stb_q;
  assign wr_if.or_wr_addr = wr_addr_q;
  assign wr_if.or_wr_data = wr_data_q;
  assign wr_if.or_busy    = busy_q;

  // Next-state logic: bus conditions first, then per-state bit handling
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], io_i2c_scl};
    sda_sync_d = {sda_sync_q[1:0], io_i2c_sda};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;
    rx_byte    = {shift_q[6:0], sda_bit};
    ptr_inc    = ptr_q + PTR_ONE;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      cnt_d     = 4'd0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                S_ADDR: begin
                  if (addr_hit) begin
                    busy_d  = 1'b1;
                    state_d = S_ACK_ADDR;
                  end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                  end
                end
                S_PTR: begin
                  ptr_d   = rx_byte[PTR_W-1:0];
                  state_d = S_ACK_PTR;
                end
                default: begin
                  regs_d[ptr_q] = rx_byte;
                  wr_stb_d      = 1'b1;
                  wr_addr_d     = ptr_q;
                  wr_data_d     = rx_byte;
                  ptr_d         = ptr_inc;
                  state_d       = S_ACK_WDATA;
                end
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // First SCL fall drives the ACK, the second releases it; rw stays in shift_q[0]
        S_ACK_ADDR, S_ACK_PTR, S_ACK_WDATA: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 4'd0;
              if (state_q == S_ACK_ADDR) begin
`ifdef I2C_SLAVE_READ_EN
                if (shift_q[0]) begin
                  state_d   = S_RDATA;
                  sda_low_d = ~regs_q[ptr_q][7];
                  shift_d   = {regs_q[ptr_q][6:0], 1'b0};
                  cnt_d     = 4'd1;
                end else begin
                  state_d = S_PTR;
                end
`else
                state_d = S_PTR;
`endif
              end else begin
                state_d = S_WDATA;
              end
            end
          end else begin
            sda_low_d = sda_low_q;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              state_d   = S_RACK;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              cnt_d     = cnt_q + 4'd1;
            end
          end else begin
            sda_low_d = sda_low_q;
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            if (!sda_bit) begin
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
              cnt_d   = 4'd0;
              state_d = S_RDATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = state_q;
          end
        end
`endif
        default: begin
          state_d   = S_IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; sync flops reset high so no edge is seen after reset
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= {PTR_W{1'b0}};
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= {PTR_W{1'b0}};
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Scoreboard bench for i2c_slave_regs: a bit-banged I2C master issues directed transactions,
// expected strobes and bus responses are queued, and monitors pop and compare them.
module tb_i2c_slave_regs;
  localparam int PTR_W = 4;
  localparam int QTR   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic m_sda_low = 1'b0;
  logic m_scl_low = 1'b0;
  wire  sda, scl;

  always #5 clk = ~clk;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (scl);

  i2c_slave_regs_if #(.PTR_W(PTR_W)) wr_if ();

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .PTR_W(PTR_W)) dut (
    .iw_clk     (clk),
    .iw_reset_n (rst_n),
    .io_i2c_sda (sda),
    .io_i2c_scl (scl),
    .wr_if      (wr_if)
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [11:0] exp_wr_q  [$];
  logic [7:0]  exp_bus_q [$];
  logic [7:0]  obs_bus_q [$];
  string       bus_name_q[$];
  logic [7:0]  model [16];
  logic        watch_low = 1'b0;
  logic        saw_low   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Strobe monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && wr_if.or_wr_stb) begin
      if (exp_wr_q.size() == 0) chk("unexpected_wr_stb", {wr_if.or_wr_addr, wr_if.or_wr_data}, 0);
      else chk("wr_stb_addr_data", {wr_if.or_wr_addr, wr_if.or_wr_data}, exp_wr_q.pop_front());
    end
  end

  // Bus monitor: compares observed ACK bits / read bytes with queued expectations
  always @(negedge clk) begin
    while (obs_bus_q.size() > 0 && exp_bus_q.size() > 0)
      chk(bus_name_q.pop_front(), obs_bus_q.pop_front(), exp_bus_q.pop_front());
  end

  // Flags any low level on SDA that the master itself is not driving
  always @(negedge clk) begin
    if (watch_low && sda === 1'b0 && !m_sda_low) saw_low <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (QTR) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b;  wait_q();
    m_scl_low = 1'b0; wait_q(); wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    exp_bus_q.push_back({7'd0, exp_ack});
    bus_name_q.push_back(name);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    obs_bus_q.push_back({7'd0, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp_b, input logic ack, input string name);
    logic [7:0] b;
    logic       x;
    exp_bus_q.push_back(exp_b);
    bus_name_q.push_back(name);
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
    obs_bus_q.push_back(b);
    put_bit(ack);
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    model[a] = d;
  endtask

  initial begin
    int nz;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_busy", wr_if.or_busy, 0);
    chk("reset_wr_stb", wr_if.or_wr_stb, 0);
    chk("reset_wr_addr_data", {wr_if.or_wr_addr, wr_if.or_wr_data}, 0);
    chk("reset_sda_released", sda, 1);
    rst_n = 1'b1;
    wait_q();

    // Reset midway through the data byte: no strobe, everything cleared
    i2c_start();
    send_byte(8'hA0, 1'b0, "rst_ack_addr");
    send_byte(8'h05, 1'b0, "rst_ack_ptr");
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    m_scl_low = 1'b0; wait_q();
    rst_n = 1'b0;
    #1;
    chk("rst_sda_released", sda, 1);
    chk("rst_busy_cleared", wr_if.or_busy, 0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.regs_q[i] != 8'h00) nz++;
    chk("rst_regs_zero", nz, 0);
    m_sda_low = 1'b0;
    wait_q();
    rst_n = 1'b1;
    wait_q();

    // Single write after reset
    i2c_start();
    send_byte(8'hA0, 1'b0, "w1_ack_addr");
    chk("w1_busy_after_addr", wr_if.or_busy, 1);
    send_byte(8'h03, 1'b0, "w1_ack_ptr");
    expect_wr(4'h3, 8'hAA);
    send_byte(8'hAA, 1'b0, "w1_ack_data");
    i2c_stop();
    wait_q();
    chk("w1_busy_after_stop", wr_if.or_busy, 0);
    chk("w1_regs3", dut.regs_q[3], 8'hAA);

    // Pointer wrap from 15 to 0
    i2c_start();
    send_byte(8'hA0, 1'b0, "w2_ack_addr");
    send_byte(8'h0F, 1'b0, "w2_ack_ptr");
    expect_wr(4'hF, 8'h11);
    send_byte(8'h11, 1'b0, "w2_ack_d0");
    expect_wr(4'h0, 8'h22);
    send_byte(8'h22, 1'b0, "w2_ack_d1");
    i2c_stop();
    wait_q();

    // Wrong address: never ACKed, never busy
    saw_low = 1'b0;
    watch_low = 1'b1;
    i2c_start();
    send_byte(8'hA2, 1'b1, "miss_nack_addr");
    watch_low = 1'b0;
    chk("miss_no_sda_low", saw_low, 0);
    chk("miss_busy", wr_if.or_busy, 0);
    i2c_stop();
    wait_q();

    // Upper pointer bits are ignored: 0xF4 selects index 4
    i2c_start();
    send_byte(8'hA0, 1'b0, "w3_ack_addr");
    send_byte(8'hF4, 1'b0, "w3_ack_ptr");
    expect_wr(4'h4, 8'h96);
    send_byte(8'h96, 1'b0, "w3_ack_data");
    i2c_stop();
    wait_q();

`ifdef I2C_SLAVE_READ_EN
    i2c_start();
    send_byte(8'hA0, 1'b0, "rd_ack_addr_w");
    send_byte(8'h03, 1'b0, "rd_ack_ptr");
    i2c_start();
    send_byte(8'hA1, 1'b0, "rd_ack_addr_r");
    recv_byte(8'hAA, 1'b0, "rd_byte0");
    recv_byte(8'h96, 1'b1, "rd_byte1");
    chk("rd_state_idle", int'(dut.state_q), 0);
    i2c_stop();
    wait_q();
`else
    i2c_start();
    send_byte(8'hA1, 1'b1, "rd_nack_addr");
    chk("rd_busy_stays_low", wr_if.or_busy, 0);
    i2c_stop();
    wait_q();
`endif

    repeat (4) wait_q();
    chk("pending_strobes", exp_wr_q.size(), 0);
    chk("pending_bus_checks", exp_bus_q.size(), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("final_regs%0d", i), dut.regs_q[i], model[i]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
